pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//  Parametrised pipeline register stage with a valid/ready handshake and a 2-entry skid buffer.
//  Sustains one transfer per cycle with no combinational path from out_ready to in_ready.
//  Sits between processor pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Adds stall (backpressure) and flush on top of a plain reset-to-zero data register.
// PARAMETERS
//  WIDTH      32   bit width of in_data / out_data / both storage registers
//  RESET_VAL  0    value loaded into both data registers on reset (WIDTH bits)
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  reset      in   1      synchronous, active-high; dominates every other input
//  flush      in   1      synchronous discard of all held entries (pipeline squash)
//  in_valid   in   1      upstream has data on in_data
//  in_ready   out  1      stage can accept; in_fire = in_valid & in_ready
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      out_data holds a valid entry
//  out_ready  in   1      downstream accepts; out_fire = out_valid & out_ready
//  out_data   out  WIDTH  payload of the oldest held entry (main register)
//  occupancy  out  2      number of held entries, 0..2
// BEHAVIOUR
//  - Storage: main register (drives out_data) + skid register; state EMPTY / ONE / FULL (occupancy 0/1/2).
//  - out_valid = (state != EMPTY); in_ready = ~reset & (state != FULL); both decode registered state only.
//  - Reset (posedge with reset=1): state=EMPTY, main=skid=RESET_VAL, occupancy=0, out_valid=0.
//    in_ready is 0 while reset is high and 1 from the first cycle after reset deasserts.
//  - EMPTY:
//    - in_fire -> main<=in_data, go ONE (data visible one cycle later).
//    - Else hold.
//  - ONE:
//    - in_fire & out_fire -> main<=in_data, stay ONE (full throughput).
//    - in_fire & !out_fire -> skid<=in_data, go FULL.
//    - !in_fire & out_fire -> go EMPTY.
//    - Neither -> hold; out_data is stable while out_valid & !out_ready.
//  - FULL:
//    - in_ready=0, so in_fire is impossible.
//    - out_fire -> main<=skid, go ONE.
//    - Else hold both registers.
//  - Latency: in_fire at cycle N -> out_valid with that data at cycle N+1 when the stage was EMPTY,
//    or when it was ONE and out_fire occurred in cycle N.
//  - Order: entries leave in acceptance order; no entry is duplicated or lost except by flush/reset.
//  - Flush (posedge with flush=1, reset=0):
//    - state<=EMPTY, occupancy<=0; data registers keep their values (don't-care, out_valid=0).
//    - flush wins over a simultaneous in_fire: the accepted word is dropped.
//    - An out_fire in the flush cycle counts as delivered.
//  - reset and flush together -> reset behaviour.
//  - Data registers load only on the transfers listed above; no enable-free loads.
//  - Protocol assumptions (checked by bench assertions):
//    - upstream holds in_valid/in_data stable until in_fire;
//    - out_valid/out_data never change while out_valid & !out_ready (guaranteed by this block).
// TESTING
//  1 Reset: hold reset 2 cycles with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, occupancy=0,
//    in_ready=0 during reset, out_data=RESET_VAL; in_ready=1 after deassert.
//  2 Streaming: out_ready=1, feed 0x1,0x2,..,0x10 on consecutive cycles -> out_data 0x1..0x10
//    one cycle later, back-to-back, occupancy stays 1, in_ready never drops.
//  3 Stall: out_ready=0, offer 0xA,0xB,0xC -> 0xA,0xB accepted, occupancy=2, in_ready=0, 0xC held
//    upstream; raise out_ready -> 0xA,0xB,0xC emerge in order with no bubble after 0xA.
//  4 Flush: FULL with 0xA,0xB, assert flush 1 cycle with in_valid=1 (0xC) and out_ready=0
//    -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xC is not delivered.
//  5 Reset mid-operation: FULL, assert reset together with flush and out_ready=1
//    -> out_valid=0, out_data=RESET_VAL, nothing emerges afterwards until a new in_fire.
//  6 Random: random in_valid/out_ready at 50% for 10k cycles vs a scoreboard queue
//    -> zero mismatches, occupancy equals the scoreboard depth every cycle.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with valid/ready handshake and a 2-entry skid buffer.
// Handshake outputs decode registered state only, so out_ready never reaches in_ready combinationally.
module pipe_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = ~reset & (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = 2'(state_q);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squash drops every held entry, including a word accepted this same cycle.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized bench for pipe_skid_reg; inputs driven and outputs sampled on negedge.
module tb_pipe_skid_reg;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    int n_cmp = 0;
    int n_err = 0;

    pipe_skid_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready cyc%0d: got %b want 0", c, in_ready); end
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", c, out_valid); end
            n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy cyc%0d: got %0d want 0", c, occupancy); end
            n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data cyc%0d: got %h want 0", c, out_data); end
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_release_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = i;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready word%0d: got %b want 1", i, in_ready); end
            step();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_out_valid word%0d: got %b want 1", i, out_valid); end
            n_cmp++; if (out_data !== 32'(i)) begin n_err++; $display("FAIL stream_out_data: got %h want %h", out_data, 32'(i)); end
            n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stream_occupancy word%0d: got %0d want 1", i, occupancy); end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL stream_drain_occupancy: got %0d want 0", occupancy); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        step();
        n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stall_occ_a: got %0d want 1", occupancy); end
        n_cmp++; if (out_data !== 32'hA) begin n_err++; $display("FAIL stall_data_a: got %h want a", out_data); end
        in_data = 32'hB;
        step();
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL stall_occ_full: got %0d want 2", occupancy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_full: got %b want 0", in_ready); end
        in_data = 32'hC;
        step();
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL stall_occ_hold: got %0d want 2", occupancy); end
        n_cmp++; if (out_data !== 32'hA) begin n_err++; $display("FAIL stall_data_hold: got %h want a", out_data); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_hold: got %b want 0", in_ready); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hB) begin n_err++; $display("FAIL stall_release_b: got v=%b %h want v=1 b", out_valid, out_data); end
        n_cmp++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin n_err++; $display("FAIL stall_release_state: got rdy=%b occ=%0d want rdy=1 occ=1", in_ready, occupancy); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hC) begin n_err++; $display("FAIL stall_release_c: got v=%b %h want v=1 c", out_valid, out_data); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL stall_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        step();
        in_data = 32'hB;
        step();
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL flush_prefill: got %0d want 2", occupancy); end
        in_data = 32'hC; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_occupancy: got %0d want 0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_leak cyc%0d: got %b want 0", c, out_valid); end
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hD;
        step();
        in_data = 32'hE; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL flush_drops_in_fire: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL rstmid_prefill: got %0d want 2", occupancy); end
        in_valid = 1'b0; reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rstmid_out_data: got %h want 0", out_data); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rstmid_occupancy: got %0d want 0", occupancy); end
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet cyc%0d: got %b want 0", c, out_valid); end
        end
        in_valid = 1'b1; in_data = 32'h55;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin n_err++; $display("FAIL rstmid_new_word: got v=%b %h want v=1 55", out_valid, out_data); end
        step();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] exp_q[$];
        logic             offering = 1'b0;
        logic [WIDTH-1:0] pend = '0;
        logic             in_f, out_f;
        for (int c = 0; c < 10000; c++) begin
            n_cmp++; if (occupancy !== 2'(exp_q.size())) begin n_err++; $display("FAIL rand_occupancy cyc%0d: got %0d want %0d", c, occupancy, exp_q.size()); end
            n_cmp++; if (out_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rand_out_valid cyc%0d: got %b want %b", c, out_valid, exp_q.size() != 0); end
            n_cmp++; if (in_ready !== (exp_q.size() < 2)) begin n_err++; $display("FAIL rand_in_ready cyc%0d: got %b want %b", c, in_ready, exp_q.size() < 2); end
            if (exp_q.size() != 0) begin
                n_cmp++; if (out_data !== exp_q[0]) begin n_err++; $display("FAIL rand_out_data cyc%0d: got %h want %h", c, out_data, exp_q[0]); end
            end
            if (!offering && $urandom_range(0, 1) == 1) begin
                offering = 1'b1;
                pend = $urandom;
            end
            in_valid  = offering;
            in_data   = pend;
            out_ready = 1'($urandom_range(0, 1));
            in_f  = offering && (exp_q.size() < 2);
            out_f = (exp_q.size() != 0) && out_ready;
            step();
            if (out_f) void'(exp_q.pop_front());
            if (in_f) begin
                exp_q.push_back(pend);
                offering = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
